// File: rtl/hdr_sha_seq.sv
// Sequences the two SHA-256 compressions of an 80-byte block header through an external core.
// Optional `MIDSTATE_REUSE_EN: skip block 0 when header[639:128] matches the stored midstate tag.
module hdr_sha_seq #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hdr_valid,
  output logic         hdr_ready,
  input  logic [639:0] header,
  output logic         core_start,
  output logic [511:0] core_block,
  output logic [255:0] core_init,
  input  logic         core_done,
  input  logic [255:0] core_hash,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest,
  output logic         busy,
  output logic         err
);

  localparam int unsigned BLK_W  = 512;
  localparam int unsigned HASH_W = 256;
  localparam int unsigned TAIL_W = 128;
  localparam int unsigned LEN_W  = 64;
  localparam int unsigned ZERO_W = BLK_W - TAIL_W - 1 - LEN_W;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [HASH_W-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [LEN_W-1:0]  MSG_BITS  = LEN_W'(640);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BLK0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_BLK1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_OUT   = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  // Second block: last 16 header bytes, the 0x80 pad byte, zeros, 64-bit message length.
  function automatic logic [BLK_W-1:0] tail_block(input logic [TAIL_W-1:0] tail);
    return {tail, 1'b1, {ZERO_W{1'b0}}, MSG_BITS};
  endfunction

  state_e              state_q, state_d;
  logic [TAIL_W-1:0]   hdr_tail_q, hdr_tail_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hdr_ready_q, hdr_ready_d;
  logic                core_start_q, core_start_d;
  logic [BLK_W-1:0]    core_block_q, core_block_d;
  logic [HASH_W-1:0]   core_init_q, core_init_d;
  logic                digest_valid_q, digest_valid_d;
  logic [HASH_W-1:0]   digest_q, digest_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

`ifdef MIDSTATE_REUSE_EN
  logic [BLK_W-1:0]    tag_q, tag_d;
  logic [HASH_W-1:0]   mid_q, mid_d;
  logic                mid_vld_q, mid_vld_d;
`endif

  // Next-state logic; every output is registered from the next state so it lines up with state_q.
  always_comb begin
    state_d      = state_q;
    hdr_tail_d   = hdr_tail_q;
    cnt_d        = cnt_q;
    core_block_d = core_block_q;
    core_init_d  = core_init_q;
    digest_d     = digest_q;
    err_d        = err_q;
`ifdef MIDSTATE_REUSE_EN
    tag_d        = tag_q;
    mid_d        = mid_q;
    mid_vld_d    = mid_vld_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (hdr_valid && hdr_ready_q) begin
          hdr_tail_d   = header[TAIL_W-1:0];
          state_d      = S_BLK0;
          core_block_d = header[639:TAIL_W];
          core_init_d  = SHA256_IV;
`ifdef MIDSTATE_REUSE_EN
          if (mid_vld_q && (header[639:TAIL_W] == tag_q)) begin
            state_d      = S_BLK1;
            core_block_d = tail_block(header[TAIL_W-1:0]);
            core_init_d  = mid_q;
          end else begin
            // Midstate is about to be replaced; it stays invalid until block 0 completes.
            tag_d     = header[639:TAIL_W];
            mid_vld_d = 1'b0;
          end
`endif
        end
      end

      S_BLK0: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT0;
      end

      S_WAIT0: begin
        if (core_done) begin
          state_d      = S_BLK1;
          core_block_d = tail_block(hdr_tail_q);
          core_init_d  = core_hash;
`ifdef MIDSTATE_REUSE_EN
          mid_d     = core_hash;
          mid_vld_d = 1'b1;
`endif
        end else if (cnt_q >= CNT_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BLK1: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT1;
      end

      S_WAIT1: begin
        if (core_done) begin
          state_d  = S_OUT;
          digest_d = core_hash;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_OUT: begin
        if (digest_ready) begin
          state_d = S_IDLE;
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    hdr_ready_d    = (state_d == S_IDLE);
    core_start_d   = (state_d == S_BLK0) || (state_d == S_BLK1);
    digest_valid_d = (state_d == S_OUT);
    busy_d         = (state_d != S_IDLE);
  end

  // cnt_q holds cycles elapsed since the last core_start while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      hdr_tail_q     <= '0;
      cnt_q          <= '0;
      hdr_ready_q    <= 1'b1;
      core_start_q   <= 1'b0;
      core_block_q   <= '0;
      core_init_q    <= '0;
      digest_valid_q <= 1'b0;
      digest_q       <= '0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_tail_q     <= hdr_tail_d;
      cnt_q          <= cnt_d;
      hdr_ready_q    <= hdr_ready_d;
      core_start_q   <= core_start_d;
      core_block_q   <= core_block_d;
      core_init_q    <= core_init_d;
      digest_valid_q <= digest_valid_d;
      digest_q       <= digest_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

`ifdef MIDSTATE_REUSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q     <= '0;
      mid_q     <= '0;
      mid_vld_q <= 1'b0;
    end else begin
      tag_q     <= tag_d;
      mid_q     <= mid_d;
      mid_vld_q <= mid_vld_d;
    end
  end
`endif

  assign hdr_ready    = hdr_ready_q;
  assign core_start   = core_start_q;
  assign core_block   = core_block_q;
  assign core_init    = core_init_q;
  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_hdr_sha_seq.sv
// Bench for hdr_sha_seq: stub compression core plus a message-level reference model of the digest.
`timescale 1ns/1ps
module tb_hdr_sha_seq;

  localparam int unsigned TO = 256;
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef MIDSTATE_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         hdr_valid = 1'b0;
  logic         hdr_ready;
  logic [639:0] header = '0;
  logic         core_start;
  logic [511:0] core_block;
  logic [255:0] core_init;
  logic         core_done = 1'b0;
  logic [255:0] core_hash = '0;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic [255:0] digest;
  logic         busy;
  logic         err;

  hdr_sha_seq #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .header(header),
    .core_start(core_start), .core_block(core_block), .core_init(core_init),
    .core_done(core_done), .core_hash(core_hash), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .digest(digest), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub core: mode 0 adds 1 to every chaining word; mode 1 also mixes in the message block.
  function automatic logic [255:0] stub_core(input logic [255:0] h, input logic [511:0] b, input bit mode);
    logic [255:0] r;
    logic [31:0]  hw, w0, w1;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      hw = h[255-32*i -: 32];
      w0 = b[511-32*i -: 32];
      w1 = b[255-32*i -: 32];
      if (mode) r[255-32*i -: 32] = hw + (w0 ^ {w1[15:0], w1[31:16]}) + 32'(i) + 32'd1;
      else      r[255-32*i -: 32] = hw + 32'd1;
    end
    return r;
  endfunction

  // Reference: pad the 640-bit message arithmetically, then chain both blocks through the stub.
  function automatic logic [255:0] ref_digest(input logic [639:0] h, input bit mode);
    logic [1023:0] msg;
    msg = ({384'b0, h} << 384) | (1024'b1 << 383) | 1024'd640;
    return stub_core(stub_core(IV, msg[1023:512], mode), msg[511:0], mode);
  endfunction

  // Stub control (written by the main process only).
  int  core_lat  = 1;
  bit  core_en   = 1'b1;
  bit  stub_mode = 1'b0;
  int  stray_cnt = 0;
  // Stub state (written by the stub process only).
  int  n_starts = 0, stab_viol = 0, stray_seen = 0, start_cyc = 0, lat_left = 0;
  bit  pend = 1'b0;
  logic [511:0] cap_blk = '0;
  logic [255:0] cap_init = '0;
  logic [511:0] blk_hist[$];
  logic [255:0] init_hist[$];

  always @(negedge clk) begin
    core_done = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (stray_seen != stray_cnt) begin
        stray_seen = stray_cnt;
        core_done  = 1'b1;
        core_hash  = {8{32'hdeadbeef}};
      end
      if (pend) begin
        if (core_block !== cap_blk || core_init !== cap_init) stab_viol++;
        if (lat_left == 0) begin
          core_done = 1'b1;
          core_hash = stub_core(cap_init, cap_blk, stub_mode);
          pend      = 1'b0;
        end else begin
          lat_left--;
        end
      end
      if (core_start === 1'b1) begin
        n_starts++;
        start_cyc = cyc;
        blk_hist.push_back(core_block);
        init_hist.push_back(core_init);
        if (core_en) begin
          pend     = 1'b1;
          cap_blk  = core_block;
          cap_init = core_init;
          lat_left = core_lat - 1;
        end
      end
    end
  end

  // Midstate reuse model: tag of the last header whose first block completed.
  logic [511:0] m_tag = '0;
  bit           m_vld = 1'b0;

  function automatic int exp_starts(input logic [639:0] h);
    bit hit;
    hit = m_vld && (h[639:128] == m_tag);
    return (hit && REUSE) ? 1 : 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_hdr(input logic [639:0] h, output bit sent);
    sent      = 1'b0;
    hdr_valid = 1'b1;
    header    = h;
    for (int i = 0; i < 50; i++) begin
      if (hdr_ready === 1'b1) begin
        sent = 1'b1;
        step();
        break;
      end
      step();
    end
    hdr_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [639:0] h, output bit ok, output logic [255:0] dig, output int starts);
    int n0;
    bit sent;
    n0 = n_starts;
    ok = 1'b0;
    offer_hdr(h, sent);
    if (sent) begin
      for (int i = 0; i < 500; i++) begin
        if (digest_valid === 1'b1) begin
          ok = 1'b1;
          break;
        end
        step();
      end
    end
    dig    = digest;
    starts = n_starts - n0;
    if (ok) begin
      m_tag = h[639:128];
      m_vld = 1'b1;
    end
  endtask

  task automatic accept_digest();
    digest_ready = 1'b1;
    step();
    digest_ready = 1'b0;
  endtask

  function automatic logic [639:0] rand_hdr();
    logic [639:0] h;
    for (int i = 0; i < 20; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst   = 1'b0;
    m_vld = 1'b0;
    checks++;
    if (hdr_ready !== 1'b1 || core_start !== 1'b0 || digest_valid !== 1'b0 || err !== 1'b0 ||
        busy !== 1'b0 || digest !== 256'h0)
      begin errors++; $display("FAIL reset_state: rdy=%b start=%b dv=%b err=%b busy=%b dig=%h (want 1 0 0 0 0 0)",
                               hdr_ready, core_start, digest_valid, err, busy, digest); end
  endtask

  task automatic test_zero_vector();
    bit ok; logic [255:0] dig, want_init1, want_dig; logic [511:0] want_b1; int st;
    stub_mode = 1'b0; core_lat = 3;
    blk_hist.delete(); init_hist.delete();
    want_b1 = 512'h280;
    want_b1[383] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want_init1[32*i +: 32] = IV[32*i +: 32] + 32'd1;
      want_dig[32*i +: 32]   = IV[32*i +: 32] + 32'd2;
    end
    run_txn('0, ok, dig, st);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout: digest_valid never rose"); end
    checks++;
    if (st != 2) begin errors++; $display("FAIL zero_starts: got %0d want 2", st); end
    checks++;
    if (blk_hist.size() != 2) begin errors++; $display("FAIL zero_hist: got %0d blocks want 2", blk_hist.size()); end
    else begin
      checks++;
      if (blk_hist[0] !== 512'h0 || init_hist[0] !== IV)
        begin errors++; $display("FAIL zero_blk0: blk=%h init=%h", blk_hist[0], init_hist[0]); end
      checks++;
      if (blk_hist[1] !== want_b1) begin errors++; $display("FAIL zero_blk1: got %h want %h", blk_hist[1], want_b1); end
      checks++;
      if (init_hist[1] !== want_init1) begin errors++; $display("FAIL zero_init1: got %h want %h", init_hist[1], want_init1); end
    end
    checks++;
    if (dig !== want_dig) begin errors++; $display("FAIL zero_digest: got %h want %h", dig, want_dig); end
    accept_digest();
    checks++;
    if (digest_valid !== 1'b0 || hdr_ready !== 1'b1)
      begin errors++; $display("FAIL zero_accept: dv=%b rdy=%b want 0 1", digest_valid, hdr_ready); end
  endtask

  task automatic test_hold();
    bit ok, bad; logic [255:0] dig; logic [639:0] h; int st;
    stub_mode = 1'b1; core_lat = int'($urandom_range(1, 6));
    h = rand_hdr();
    run_txn(h, ok, dig, st);
    checks++;
    if (!ok || dig !== ref_digest(h, 1'b1))
      begin errors++; $display("FAIL hold_digest: ok=%b got %h want %h", ok, dig, ref_digest(h, 1'b1)); end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (digest_valid !== 1'b1 || digest !== dig || hdr_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL hold_stable: dv=%b dig=%h rdy=%b want 1 %h 0", digest_valid, digest, hdr_ready, dig); end
    accept_digest();
    checks++;
    if (digest_valid !== 1'b0 || hdr_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL hold_accept: dv=%b rdy=%b busy=%b want 0 1 0", digest_valid, hdr_ready, busy); end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [255:0] dig; logic [639:0] h; int st, want_st;
    stub_mode = 1'b1;
    h = rand_hdr();
    for (int n = 0; n < 10; n++) begin
      if (n % 3 == 1) h[31:0] = $urandom;
      else            h = rand_hdr();
      core_lat = int'($urandom_range(1, 8));
      want_st  = exp_starts(h);
      run_txn(h, ok, dig, st);
      checks++;
      if (!ok || dig !== ref_digest(h, 1'b1))
        begin errors++; $display("FAIL b2b_digest[%0d]: ok=%b got %h want %h", n, ok, dig, ref_digest(h, 1'b1)); end
      checks++;
      if (st != want_st) begin errors++; $display("FAIL b2b_starts[%0d]: got %0d want %0d", n, st, want_st); end
      repeat ($urandom_range(0, 3)) step();
      accept_digest();
    end
    checks++;
    if (stab_viol != 0) begin errors++; $display("FAIL core_inputs_stable: %0d unstable cycles want 0", stab_viol); end
  endtask

  task automatic test_nonce_reuse();
    bit ok; logic [255:0] dig; logic [639:0] h; int st;
    stub_mode = 1'b1; core_lat = 2;
    h = rand_hdr();
    run_txn(h, ok, dig, st);
    accept_digest();
    h[31:0] = h[31:0] ^ 32'h0000_1234;
    run_txn(h, ok, dig, st);
    checks++;
    if (st != (REUSE ? 1 : 2)) begin errors++; $display("FAIL nonce_starts: got %0d want %0d", st, REUSE ? 1 : 2); end
    checks++;
    if (!ok || dig !== ref_digest(h, 1'b1))
      begin errors++; $display("FAIL nonce_digest: ok=%b got %h want %h", ok, dig, ref_digest(h, 1'b1)); end
    accept_digest();
  endtask

  task automatic test_stray_idle();
    int n0; bit bad;
    n0 = n_starts;
    stray_cnt++;
    bad = 1'b0;
    repeat (5) begin
      step();
      if (busy !== 1'b0 || digest_valid !== 1'b0 || hdr_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || n_starts != n0)
      begin errors++; $display("FAIL stray_idle: busy=%b dv=%b rdy=%b starts=%0d want 0 0 1 0", busy, digest_valid, hdr_ready, n_starts - n0); end
  endtask

  task automatic test_rst_mid();
    bit sent, seen, bad; int n0, want;
    stub_mode = 1'b1; core_lat = 15;
    n0   = n_starts;
    header = rand_hdr();
    want = exp_starts(header);
    offer_hdr(header, sent);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (n_starts - n0 == want) begin seen = 1'b1; break; end
      step();
    end
    checks++;
    if (!sent || !seen) begin errors++; $display("FAIL rstmid_reach: sent=%b second start seen=%b want 1 1", sent, seen); end
    rst = 1'b1;
    step();
    rst   = 1'b0;
    m_vld = 1'b0;
    stray_cnt++;
    checks++;
    if (hdr_ready !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0 || digest !== 256'h0)
      begin errors++; $display("FAIL rstmid_state: rdy=%b busy=%b start=%b dig=%h want 1 0 0 0", hdr_ready, busy, core_start, digest); end
    bad = 1'b0;
    repeat (20) begin
      step();
      if (digest_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rstmid_stray: digest_valid/busy rose after stray core_done, dv=%b busy=%b", digest_valid, busy); end
  endtask

  task automatic test_timeout();
    bit sent, seen, bad; int n0, err_cyc;
    core_en = 1'b0;
    offer_hdr(rand_hdr(), sent);
    seen = 1'b0; err_cyc = 0;
    for (int i = 0; i < TO + 100; i++) begin
      if (err === 1'b1) begin seen = 1'b1; err_cyc = cyc; break; end
      step();
    end
    checks++;
    if (!sent || !seen) begin errors++; $display("FAIL timeout_err: sent=%b err seen=%b want 1 1", sent, seen); end
    checks++;
    if (err_cyc - start_cyc != int'(TO))
      begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", err_cyc - start_cyc, TO); end
    n0 = n_starts; bad = 1'b0;
    repeat (10) begin
      step();
      if (err !== 1'b1 || hdr_ready !== 1'b0 || digest_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || n_starts != n0)
      begin errors++; $display("FAIL err_sticky: err=%b rdy=%b dv=%b busy=%b starts=%0d want 1 0 0 1 0", err, hdr_ready, digest_valid, busy, n_starts - n0); end
    rst = 1'b1;
    step();
    rst     = 1'b0;
    m_vld   = 1'b0;
    core_en = 1'b1;
    checks++;
    if (err !== 1'b0 || hdr_ready !== 1'b1)
      begin errors++; $display("FAIL err_clear: err=%b rdy=%b want 0 1", err, hdr_ready); end
  endtask

  task automatic test_recover();
    bit ok; logic [255:0] dig; logic [639:0] h; int st;
    stub_mode = 1'b1; core_lat = 4;
    h = rand_hdr();
    run_txn(h, ok, dig, st);
    checks++;
    if (!ok || dig !== ref_digest(h, 1'b1) || st != 2)
      begin errors++; $display("FAIL recover: ok=%b starts=%0d got %h want %h", ok, st, dig, ref_digest(h, 1'b1)); end
    accept_digest();
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_hold();
    test_back_to_back();
    test_nonce_reuse();
    test_stray_idle();
    test_rst_mid();
    test_timeout();
    test_recover();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hdr_sha_seq.md
HDR_SHA_SEQ -- requirements
Module: hdr_sha_seq

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 256, max cycles waited for core_done after core_start before error.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 hdr_valid  input  1  header offered.
REQ-005 hdr_ready  output  1  block accepts header; transfer when hdr_valid && hdr_ready.
REQ-006 header  input  640  80-byte block header, byte 0 in [639:632].
REQ-007 core_start  output  1  one-cycle pulse launching one SHA-256 compression.
REQ-008 core_block  output  512  message block for current compression.
REQ-009 core_init  output  256  chaining value in, H0 in [255:224].
REQ-010 core_done  input  1  one-cycle pulse, compression finished.
REQ-011 core_hash  input  256  updated chaining value, valid only when core_done=1.
REQ-012 digest_valid  output  1  digest available.
REQ-013 digest_ready  input  1  consumer accepts digest; transfer when both high.
REQ-014 digest  output  256  SHA-256 of header.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 err  output  1  sticky timeout flag.

Function
REQ-017 States: IDLE, BLK0, WAIT0, BLK1, WAIT1, OUT, ERR.
REQ-018 hdr_ready=1 only in IDLE; on transfer, header captured into internal register and state -> BLK0.
REQ-019 Padded message: bits [1023:384]=header, bit 383=1, bits [382:64]=0, bits [63:0]=64'd640 (0x280).
REQ-020 Block 0 = padded[1023:512]; block 1 = padded[511:0].
REQ-021 BLK0: core_start=1 for exactly one cycle, core_block=block 0, core_init=SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19); next state WAIT0.
REQ-022 core_block and core_init SHALL stay stable from core_start until core_done cycle inclusive.
REQ-023 WAIT0: on core_done, core_hash latched as midstate, -> BLK1.
REQ-024 BLK1: one-cycle core_start, core_block=block 1, core_init=midstate; -> WAIT1.
REQ-025 WAIT1: on core_done, core_hash latched into digest, -> OUT.
REQ-026 OUT: digest_valid=1, digest stable until digest_ready=1; on transfer -> IDLE.
REQ-027 core_done outside WAIT0/WAIT1 SHALL be ignored.
REQ-028 Timeout counter cleared at each core_start, increments each WAIT cycle; reaching TIMEOUT_CYC without core_done -> ERR, err=1.
REQ-029 ERR: no core_start, hdr_ready=0, digest_valid=0; exits only via rst.
REQ-030 Minimum header-accept to digest_valid latency: 4 cycles plus both core latencies.

Reset
REQ-031 rst=1 at any state, including mid-compression: state IDLE, core_start=0, digest_valid=0, err=0, digest=0, timeout counter=0, midstate valid flag=0.
REQ-032 After rst deassertion hdr_ready=1 the first cycle; a core_done arriving from an aborted compression SHALL be ignored.

Configuration
REQ-033 Macro MIDSTATE_REUSE_EN: when defined, block stores header[639:128] tag and midstate-valid flag set on WAIT0 completion.
REQ-034 With MIDSTATE_REUSE_EN, accepted header whose [639:128] equals tag while flag set SHALL go IDLE -> BLK1 directly, skipping block 0.
REQ-035 Without MIDSTATE_REUSE_EN, every header performs both compressions; no tag storage synthesized.

Verification
REQ-036 Header=all-zero, stub core returns H+1 per word -> core_block of block 1 = {128'h0, 1'b1, 319'h0, 64'h280}; two core_start pulses; digest = IV+2 per word.
REQ-037 digest_ready held low 10 cycles in OUT -> digest_valid stays 1, digest unchanged, hdr_ready=0 throughout.
REQ-038 Core never asserts core_done, TIMEOUT_CYC=256 -> err=1 exactly 256 cycles after core_start; rst clears err, hdr_ready=1.
REQ-039 rst pulsed in WAIT1, stray core_done next cycle -> state IDLE, digest_valid never asserts.
REQ-040 MIDSTATE_REUSE_EN: two headers differing only in nonce (header[31:0]) -> second header produces one core_start only; without macro, two.
